sd_card_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single SD card command interface (block address, enable, write-enable, serial count, complete/fail) between `NUM_REQ` independent requesters. It sits between client logic (file-system engine, DMA, debug port) and the SD card top level. It holds off all traffic until card initialisation completes, issues one multi-block transaction at a time, and retries failed transactions. Its one-hot grant vector also steers the external data-port muxes.

---
 rtl/sd_card_req_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_sd_card_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_req_arbiter.sv
// sd_card_req_arbiter
// Round-robin arbiter and sequencer that shares one SD card command port
// between NUM_REQ requesters. Nothing is granted until the card reports
// initialisation complete. One multi-block transaction runs at a time, and a
// failed transaction is re-issued up to MAX_RETRY times before Req_Fail.
// The one-hot Req_Grant also steers the external data-port muxes.
// Optional feature: define SD_ARB_TIMEOUT_EN to enable a per-attempt BUSY
// watchdog of TIMEOUT_CYC cycles and the sticky Timeout_Flag.

module sd_card_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     Req_Valid,
  input  logic [NUM_REQ-1:0]     Req_we,
  input  logic [32*NUM_REQ-1:0]  Req_Addr_Block,
  input  logic [32*NUM_REQ-1:0]  Req_SerialCount,
  output logic [NUM_REQ-1:0]     Req_Grant,
  output logic [NUM_REQ-1:0]     Req_Done,
  output logic [NUM_REQ-1:0]     Req_Fail,
  output logic                   Busy,
  output logic                   Timeout_Flag,
  output logic [31:0]            SD_Addr_Block,
  output logic [31:0]            SD_SerialCount,
  output logic                   SD_we,
  output logic                   SD_Enable,
  input  logic                   SD_Complite,
  input  logic                   SD_Fail,
  input  logic                   SD_Init_Complite,
  input  logic                   SD_Init_Fail
);

  // Index width for requester numbers and retry counter width.
  // A zero-retry build still needs a 1-bit counter to keep the logic legal.
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_BUSY      = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_INIT_FAIL = 3'd5
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_owner;
  logic [RW-1:0]        r_retry;
  logic                 r_result_ok;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   r_fail;
  logic                 r_busy;
  logic                 r_sd_enable;
  logic                 r_sd_we;
  logic [31:0]          r_sd_addr;
  logic [31:0]          r_sd_count;

  logic [31:0]          w_req_addr  [NUM_REQ];
  logic [31:0]          w_req_count [NUM_REQ];
  int                   w_scan;
  logic [PW-1:0]        w_scan_idx;
  logic [PW-1:0]        w_pick_idx;
  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [PW-1:0]        w_next_ptr;
  logic                 w_timeout_hit;

  // Unpack the per-requester address and count buses into arrays
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_addr[gi]  = Req_Addr_Block[32*gi +: 32];
      assign w_req_count[gi] = Req_SerialCount[32*gi +: 32];
    end
  endgenerate

  // Round-robin pick: scan offsets from the pointer downwards so the
  // smallest offset with a valid request is the one left in w_pick_idx
  always_comb begin
    w_scan     = 0;
    w_scan_idx = '0;
    w_pick_idx = r_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= NUM_REQ) begin
        w_scan = w_scan - NUM_REQ;
      end
      w_scan_idx = PW'(w_scan);
      if (Req_Valid[w_scan_idx]) begin
        w_pick_idx = w_scan_idx;
      end
    end
  end

  assign w_pick_onehot = NUM_REQ'(1) << w_pick_idx;

  // Pointer moves past the owner when its transaction finishes
  assign w_next_ptr = (r_owner == LAST_IDX) ? '0 : r_owner + PW'(1);

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  logic [31:0] r_to_count;
  logic        r_timeout_flag;

  // Per-attempt watchdog: restarts in ISSUE, counts every BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_count <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_to_count <= '0;
    end else if (r_state == ST_BUSY) begin
      r_to_count <= r_to_count + 32'd1;
    end
  end

  assign w_timeout_hit = (r_state == ST_BUSY) && (r_to_count == TO_LAST);

  // Sticky record that a watchdog expiry ended an attempt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_flag <= 1'b0;
    end else if (w_timeout_hit && !SD_Complite) begin
      r_timeout_flag <= 1'b1;
    end
  end

  assign Timeout_Flag = r_timeout_flag;
`else
  // No watchdog: BUSY waits for the core indefinitely
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout_hit        = 1'b0;
  assign Timeout_Flag         = 1'b0;
`endif

  // Sequencer: init gating, arbitration, issue, completion and retry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_WAIT_INIT;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_retry     <= '0;
      r_result_ok <= 1'b0;
      r_grant     <= '0;
      r_done      <= '0;
      r_fail      <= '0;
      r_busy      <= 1'b0;
      r_sd_enable <= 1'b0;
      r_sd_we     <= 1'b0;
      r_sd_addr   <= '0;
      r_sd_count  <= '0;
    end else begin
      // Done/fail are single-cycle pulses
      r_done <= '0;
      r_fail <= '0;
      case (r_state)
        ST_WAIT_INIT: begin
          if (SD_Init_Fail) begin
            r_state <= ST_INIT_FAIL;
            r_busy  <= 1'b1;
          end else if (SD_Init_Complite) begin
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (|Req_Valid) begin
            r_owner    <= w_pick_idx;
            r_grant    <= w_pick_onehot;
            r_sd_we    <= Req_we[w_pick_idx];
            r_sd_addr  <= w_req_addr[w_pick_idx];
            r_sd_count <= w_req_count[w_pick_idx];
            r_retry    <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_sd_enable <= 1'b1;
          r_state     <= ST_BUSY;
        end

        ST_BUSY: begin
          // Success wins over failure or watchdog expiry in the same cycle
          if (SD_Complite) begin
            r_result_ok <= 1'b1;
            r_sd_enable <= 1'b0;
            r_state     <= ST_RELEASE;
          end else if (SD_Fail || w_timeout_hit) begin
            r_result_ok <= 1'b0;
            r_sd_enable <= 1'b0;
            r_state     <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          // Let the core drop its status before deciding what comes next
          if (!SD_Complite && !SD_Fail) begin
            if (r_result_ok) begin
              r_done  <= r_grant;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_ptr   <= w_next_ptr;
              r_state <= ST_IDLE;
            end else if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + RW'(1);
              r_state <= ST_ISSUE;
            end else begin
              r_fail  <= r_grant;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_ptr   <= w_next_ptr;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_INIT_FAIL: begin
          r_state <= ST_INIT_FAIL;
        end

        default: begin
          r_state <= ST_WAIT_INIT;
        end
      endcase
    end
  end

  assign Req_Grant      = r_grant;
  assign Req_Done       = r_done;
  assign Req_Fail       = r_fail;
  assign Busy           = r_busy;
  assign SD_Addr_Block  = r_sd_addr;
  assign SD_SerialCount = r_sd_count;
  assign SD_we          = r_sd_we;
  assign SD_Enable      = r_sd_enable;

endmodule

// File: tb/tb_sd_card_req_arbiter.sv
// tb_sd_card_req_arbiter
// Randomised requests and core responses against a transaction-level model
// of the round-robin arbiter: predicted owner, latched fields, number of
// SD_Enable attempts, final done/fail pulse and cycle-exact handshakes.

module tb_sd_card_req_arbiter;

  localparam int N  = 3;
  localparam int MR = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_we;
  logic [32*N-1:0]    req_addr;
  logic [32*N-1:0]    req_cnt;
  logic [N-1:0]       Req_Grant;
  logic [N-1:0]       Req_Done;
  logic [N-1:0]       Req_Fail;
  logic               Busy;
  logic               Timeout_Flag;
  logic [31:0]        SD_Addr_Block;
  logic [31:0]        SD_SerialCount;
  logic               SD_we;
  logic               SD_Enable;
  logic               sd_complite;
  logic               sd_fail;
  logic               sd_init_ok;
  logic               sd_init_fail;

  int n_vec = 0;
  int n_bad = 0;
  int m_ptr = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  sd_card_req_arbiter #(
    .NUM_REQ     (N),
    .MAX_RETRY   (MR),
    .TIMEOUT_CYC (1000000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .Req_Valid        (req_valid),
    .Req_we           (req_we),
    .Req_Addr_Block   (req_addr),
    .Req_SerialCount  (req_cnt),
    .Req_Grant        (Req_Grant),
    .Req_Done         (Req_Done),
    .Req_Fail         (Req_Fail),
    .Busy             (Busy),
    .Timeout_Flag     (Timeout_Flag),
    .SD_Addr_Block    (SD_Addr_Block),
    .SD_SerialCount   (SD_SerialCount),
    .SD_we            (SD_we),
    .SD_Enable        (SD_Enable),
    .SD_Complite      (sd_complite),
    .SD_Fail          (sd_fail),
    .SD_Init_Complite (sd_init_ok),
    .SD_Init_Fail     (sd_init_fail)
  );

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_fields(input int i);
    req_we[i]             = 1'($urandom_range(0, 1));
    req_addr[32*i +: 32]  = $urandom;
    req_cnt[32*i +: 32]   = 32'($urandom_range(1, 64));
  endtask

  // First requester at or after the pointer, wrapping around
  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Runs one transaction; entered on a negedge with the DUT idle and
  // req_valid already set. nf = number of core failures before success
  // (nf > MR means every attempt fails).
  task automatic run_txn(input int nf);
    int           w;
    int           attempts;
    int           h;
    logic         ok;
    logic [95:0]  exp_f;
    logic [N-1:0] onehot;
    w = rr_pick(req_valid, m_ptr);
    if (w < 0) begin
      check_val("no_request_to_run", 96'(req_valid), 96'(1));
      return;
    end
    onehot    = '0;
    onehot[w] = 1'b1;
    exp_f     = {31'b0, req_we[w], req_addr[32*w +: 32], req_cnt[32*w +: 32]};
    ok        = (nf <= MR);
    attempts  = ok ? nf + 1 : MR + 1;

    tick;
    check_val("pulse_clear", {Req_Done, Req_Fail}, 0);
    check_val("grant", 96'(Req_Grant), 96'(onehot));
    check_val("fields", {SD_we, SD_Addr_Block, SD_SerialCount}, exp_f);
    check_val("issue_enable_low", 96'(SD_Enable), 0);
    // Requester inputs change mid-transaction; the latched fields must not
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < N; i++) rand_fields(i);
    end
    if ($urandom_range(0, 3) == 0) req_valid[w] = 1'b0;

    for (int a = 0; a < attempts; a++) begin
      tick;
      check_val("enable_on", 96'(SD_Enable), 96'(1));
      check_val("busy_grant", {Busy, Req_Grant}, {1'b1, onehot});
      check_val("fields_stable", {SD_we, SD_Addr_Block, SD_SerialCount}, exp_f);
      repeat ($urandom_range(0, 5)) tick;
      if (a == attempts - 1 && ok) begin
        sd_complite = 1'b1;
        sd_fail     = 1'($urandom_range(0, 1));
      end else begin
        sd_fail     = 1'b1;
      end
      h = int'($urandom_range(1, 3));
      tick;
      check_val("enable_off", 96'(SD_Enable), 0);
      repeat (h - 1) tick;
      sd_complite = 1'b0;
      sd_fail     = 1'b0;
      tick;
      if (a < attempts - 1) begin
        check_val("retry_no_pulse", {Req_Done, Req_Fail, SD_Enable}, 0);
        check_val("retry_grant", 96'(Req_Grant), 96'(onehot));
      end
    end

    check_val("done_pulse", 96'(Req_Done), ok ? 96'(onehot) : 96'(0));
    check_val("fail_pulse", 96'(Req_Fail), ok ? 96'(0) : 96'(onehot));
    check_val("release_idle", {Req_Grant, Busy, SD_Enable}, 0);
    check_val("timeout_flag", 96'(Timeout_Flag), 0);
    m_ptr        = (w + 1) % N;
    req_valid[w] = 1'b0;
    $display("txn %0d owner %0d addr 0x%08h attempts %0d result %s",
             n_txn, w, exp_f[63:32], attempts, ok ? "done" : "fail");
    n_txn++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid    = '0;
    sd_complite  = 1'b0;
    sd_fail      = 1'b0;
    sd_init_ok   = 1'b0;
    sd_init_fail = 1'b0;
    for (int i = 0; i < N; i++) rand_fields(i);

    // Reset values
    repeat (3) tick;
    check_val("rst_outputs", {Req_Grant, Req_Done, Req_Fail, Busy, Timeout_Flag, SD_Enable, SD_we}, 0);
    check_val("rst_fields", {SD_Addr_Block, SD_SerialCount}, 0);

    // Init gating: request pending but card not ready
    rst          = 1'b0;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick;
      if (c % 10 == 9) check_val("init_gate", {Req_Grant, SD_Enable, Busy}, 0);
    end
    sd_init_ok = 1'b1;
    tick;
    check_val("idle_reached", {Req_Grant, SD_Enable}, 0);
    run_txn(0);

    // Retry exhaustion with a fixed address
    req_valid         = 3'b001;
    req_addr[31:0]    = 32'h0000_1234;
    run_txn(MR + 1);

    // Round robin with all requesters continuously asking
    for (int t = 0; t < 2 * N; t++) begin
      req_valid = '1;
      run_txn(0);
    end

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          rand_fields(i);
        end
      end
      if (req_valid == '0) begin
        tick;
        check_val("idle_no_grant", {Req_Grant, Busy, SD_Enable}, 0);
        req_valid[$urandom_range(0, N - 1)] = 1'b1;
      end
      run_txn(int'($urandom_range(0, MR + 1)));
    end

    // Reset in the middle of BUSY
    req_valid = '1;
    begin
      int           w;
      logic [N-1:0] oh;
      w     = rr_pick(req_valid, m_ptr);
      oh    = '0;
      oh[w] = 1'b1;
      tick;
      check_val("pre_rst_grant", 96'(Req_Grant), 96'(oh));
      tick;
      check_val("pre_rst_enable", 96'(SD_Enable), 96'(1));
    end
    #2 rst = 1'b1;
    #1 check_val("async_rst", {SD_Enable, Req_Grant, Busy}, 0);
    tick;
    check_val("rst_no_pulse", {Req_Done, Req_Fail}, 0);
    rst   = 1'b0;
    m_ptr = 0;
    tick;
    check_val("post_rst_idle", {Req_Grant, Req_Done, Req_Fail, SD_Enable}, 0);
    run_txn(int'($urandom_range(0, MR + 1)));

    // Init failure is terminal; both init inputs high selects failure
    tick;
    rst = 1'b1;
    tick;
    rst          = 1'b0;
    sd_init_fail = 1'b1;
    req_valid    = '1;
    for (int c = 0; c < 100; c++) begin
      tick;
      check_val("init_fail_quiet", {Req_Grant, Req_Done, Req_Fail, SD_Enable}, 0);
    end
    rst = 1'b1;
    tick;
    rst          = 1'b0;
    sd_init_ok   = 1'b0;
    sd_init_fail = 1'b0;
    m_ptr        = 0;
    repeat (5) tick;
    check_val("back_in_wait_init", {Req_Grant, SD_Enable, Busy}, 0);
    sd_init_ok = 1'b1;
    tick;
    check_val("idle_after_reinit", {Req_Grant, SD_Enable}, 0);
    run_txn(int'($urandom_range(0, MR + 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
